prime_seq_gen: RTL
==================

Name: prime_seq_gen

Overview:
- Parametrised successor to the fixed 4-bit prime counter.
- Steps through the primes representable in WIDTH bits, up or down, one prime per accepted step request.
- Finds the next prime with a sequential trial-division search FSM rather than hard-coded toggle equations, so it scales with WIDTH.
- Sits beside the existing counter as the general prime sequence source. It has a request/done handshake and a wrap indication.

Parameters:
- WIDTH, 8, bit width of the prime value. Legal range 3..16. Largest prime P_max is the largest prime ≤ 2^WIDTH-1 (251 for WIDTH=8).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  step request; sampled only in IDLE.
- dir  in  1  0 = step to next larger prime, 1 = step to next smaller prime; sampled with en.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when qn has just been updated.
- wrap  out  1  one-cycle pulse, coincident with done, when the step wrapped around the sequence ends.
- qn  out  WIDTH  current prime.

Behaviour:
- Reset (async, rst=1): qn=2, busy=0, done=0, wrap=0, state=IDLE. Reset mid-search abandons the search; qn returns to 2.
- States: IDLE, TEST.
- Registers: cand (WIDTH), d (WIDTH), dir_q.
- IDLE, en=1 at edge N:
  - dir_q<=dir, busy<=1, d<=2, state<=TEST.
  - cand<=qn+1 (up) or qn-1 (down).
  - Down from qn=2: cand<=2^WIDTH-1 and a wrap flag is set.
- IDLE, en=0: hold. en is ignored while busy (no queuing).
- TEST, one divisor per cycle. d*d is computed at 2*WIDTH bits, so it never overflows.
  - d*d > cand: cand is prime. qn<=cand, done<=1, wrap<=flag, busy<=0, state<=IDLE.
  - else cand % d == 0: reject. cand<=cand±1, d<=2.
  - else: d<=d+1.
- Up overflow: a reject when cand==2^WIDTH-1 sets qn<=2, done<=1, wrap<=1, busy<=0, state<=IDLE in that same cycle.
- Latency: qn updates at edge N+k, where k = total TEST cycles. done and wrap are high the cycle after that edge. Examples:
  - 2→3: k=1.
  - 7→11: k=7.
- done and wrap last exactly one cycle.
- qn is always prime. cand never goes below 2.

Optional Feature:
- Macro: PRIME_SKIP_EVEN_EN.
- Defined:
  - For qn≥3, candidates step by ±2 (odd only), and trial divisors start at 3 and step by 2.
  - Exceptions: up from 2 gives cand=3; down from 3 gives cand=2, which is accepted with d=2.
  - Example latency: 7→11 k=3.
  - Up overflow triggers when cand+2 > 2^WIDTH-1.
- Not defined: the ±1 / divisor+1 behaviour above.

Test Plan:
- Reset, then 6 up-steps (WIDTH=8, dir=0): qn = 3,5,7,11,13,17, each with one done pulse, wrap=0. 2→3 k=1; 7→11 k=7 (k=3 with PRIME_SKIP_EVEN_EN).
- From qn=251, step up: qn=2, wrap=1, done=1 after k=14.
- From qn=2, step down: qn=251, wrap=1. Next step down: qn=241, wrap=0.
- en held high continuously: exactly one step per IDLE visit. Pulses of en while busy=1 are ignored; qn changes once.
- Assert rst during TEST (e.g. mid 251→2 search): qn=2, busy=0, done=0 immediately, without waiting for a clock edge. The next en steps normally to 3.
- WIDTH=4 regression: up sequence 2,3,5,7,11,13,2 (wrap on 13→2) matches the legacy counter's sequence.

Source files
------------

// File: rtl/prime_seq_gen.sv
// Parametrised prime sequence generator: steps up/down through the primes below 2^WIDTH
// using a trial-division search FSM. Optional macro PRIME_SKIP_EVEN_EN restricts the search to odd values.
module prime_seq_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] qn
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TEST = 1'b1;

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] THREE   = WIDTH'(3);
`ifdef PRIME_SKIP_EVEN_EN
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(2);
    localparam logic [WIDTH-1:0] D_FIRST = WIDTH'(3);
    localparam logic [WIDTH-1:0] D_STEP  = WIDTH'(2);
`else
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(1);
    localparam logic [WIDTH-1:0] D_FIRST = WIDTH'(2);
    localparam logic [WIDTH-1:0] D_STEP  = WIDTH'(1);
`endif

    logic [0:0]         state_r;
    logic [WIDTH-1:0]   cand_r;
    logic [WIDTH-1:0]   d_r;
    logic               dir_r;
    logic               flag_r;
    logic [WIDTH-1:0]   qn_r;
    logic               busy_r;
    logic               done_r;
    logic               wrap_r;

    logic [2*WIDTH-1:0] d_wide_s;
    logic [2*WIDTH-1:0] cand_wide_s;
    logic [2*WIDTH-1:0] sq_s;
    logic               is_prime_s;
    logic               divides_s;
    logic               up_ovf_s;
    logic [WIDTH-1:0]   start_cand_s;
    logic [WIDTH-1:0]   start_d_s;
    logic               start_wrap_s;

    // Square and divisibility test for the current divisor; the square is double width so it never overflows
    always_comb begin
        d_wide_s    = {{WIDTH{1'b0}}, d_r};
        cand_wide_s = {{WIDTH{1'b0}}, cand_r};
        sq_s        = d_wide_s * d_wide_s;
        is_prime_s  = (sq_s > cand_wide_s);
        if (d_r != {WIDTH{1'b0}}) begin
            divides_s = ((cand_r % d_r) == {WIDTH{1'b0}});
        end else begin
            divides_s = 1'b0;
        end
        up_ovf_s = (cand_r > (MAX_VAL - STEP));
    end

    // First candidate and divisor when a step request is accepted
    always_comb begin
        start_cand_s = TWO;
        start_wrap_s = 1'b0;
        if (dir) begin
            if (qn_r == TWO) begin
                start_cand_s = MAX_VAL;
                start_wrap_s = 1'b1;
`ifdef PRIME_SKIP_EVEN_EN
            end else if (qn_r == THREE) begin
                start_cand_s = TWO;
                start_wrap_s = 1'b0;
`endif
            end else begin
                start_cand_s = qn_r - STEP;
                start_wrap_s = 1'b0;
            end
        end else begin
            if (qn_r == TWO) begin
                start_cand_s = THREE;
                start_wrap_s = 1'b0;
            end else if (qn_r > (MAX_VAL - STEP)) begin
                // no larger value fits: 2 is accepted in one cycle and flagged as a wrap
                start_cand_s = TWO;
                start_wrap_s = 1'b1;
            end else begin
                start_cand_s = qn_r + STEP;
                start_wrap_s = 1'b0;
            end
        end
        if (start_cand_s == TWO) begin
            start_d_s = TWO;
        end else begin
            start_d_s = D_FIRST;
        end
    end

    // Search FSM: one trial divisor per TEST cycle, registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cand_r  <= TWO;
            d_r     <= TWO;
            dir_r   <= 1'b0;
            flag_r  <= 1'b0;
            qn_r    <= TWO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (en) begin
                        dir_r   <= dir;
                        busy_r  <= 1'b1;
                        cand_r  <= start_cand_s;
                        d_r     <= start_d_s;
                        flag_r  <= start_wrap_s;
                        state_r <= S_TEST;
                    end
                end
                S_TEST: begin
                    if (is_prime_s) begin
                        qn_r    <= cand_r;
                        done_r  <= 1'b1;
                        wrap_r  <= flag_r;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (divides_s) begin
                        if (!dir_r && up_ovf_s) begin
                            qn_r    <= TWO;
                            done_r  <= 1'b1;
                            wrap_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_IDLE;
                        end else begin
                            cand_r <= dir_r ? (cand_r - STEP) : (cand_r + STEP);
                            d_r    <= D_FIRST;
                        end
                    end else begin
                        d_r <= d_r + D_STEP;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign qn   = qn_r;
    assign busy = busy_r;
    assign done = done_r;
    assign wrap = wrap_r;

endmodule
